mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter that shares one PicoRV32-style native memory slave port between two requesters. Typical use: the CPU on master 0 and a DMA or UART boot-loader engine on master 1, with the slave side feeding the existing address decoder for RAM, LED and UART. Arbitration is round-robin with the grant held until the transaction completes. A per-transaction watchdog terminates transfers that no slave ever acknowledges.

## Interface
- TIMEOUT_CYCLES, 255: slave-stall cycles tolerated before a forced error completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timeout completion.
- clk  in  1  clock; all logic rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- m0_valid, m1_valid  in  1  request valid; held by master until its ready.
- m0_instr, m1_instr  in  1  instruction-fetch qualifier.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_ready, m1_ready  out  1  transfer complete to that master.
- m0_rdata, m1_rdata  out  32  read data to that master.
- s_valid  out  1  request to slave.
- s_instr  out  1  forwarded instr.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- timeout_err  out  1  one-cycle pulse on a watchdog completion.

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE: s_valid=0; s_instr, s_addr, s_wdata and s_wstrb are 0. Both m*_ready=0.
- Arbitration in IDLE:
  - Only one master valid: that master is granted.
  - Both valid: the master that was not granted last wins (last_grant register).
  - Transition to GRANTx on the next edge.
- GRANTx: s_* are combinational copies of master x inputs. s_valid=mx_valid.
  - mx_ready=s_ready and mx_rdata=s_rdata.
  - The non-granted master sees ready=0 and rdata=0.
- Completion: s_ready=1 in GRANTx → IDLE next edge; last_grant←x.
- Master drops valid while granted (protocol abort): → IDLE next edge. No ready is issued. last_grant←x.
- Watchdog: stall_cnt clears on entry to GRANTx and increments each GRANT cycle with s_ready=0.
  - In the GRANT cycle where stall_cnt==TIMEOUT_CYCLES:
    - s_valid is forced to 0.
    - mx_ready=1 and mx_rdata=ERR_RDATA.
    - timeout_err=1 (registered, so it is visible the following cycle).
    - → IDLE; last_grant←x.
  - A write completed this way is dropped.
  - If s_ready=1 in that same cycle, the normal completion wins and no error is raised.
- stall_cnt width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

## Timing
- Reset values: state=IDLE, last_grant=1 (master 0 wins the first tie), stall_cnt=0, timeout_err=0. All outputs are 0 during and after reset.
- Arbitration latency: request at cycle t (state IDLE) → s_valid=1 at t+1.
- Ready path: s_ready → mx_ready is combinational, zero cycles.
- Minimum one IDLE cycle between consecutive grants, so the earliest next s_valid is two cycles after the completion cycle.
- Reset asserted mid-transaction: state→IDLE on that edge. No ready is issued and the slave request is dropped.
- Timeout: with TIMEOUT_CYCLES=N and no slave response, s_valid is high for N cycles. The error completion occurs in cycle N+1 of the grant. timeout_err pulses in cycle N+2.

## Structure
- Shared package mem_bus_pkg holds:
  - state encoding (IDLE/GRANT0/GRANT1);
  - constant BUS_ERR_RDATA=32'hDEAD_BEEF;
  - the decoder address constants 32'h0200_0000/4/8, so the arbiter, decoder and firmware headers agree.
- One natural sub-module: bus_watchdog, containing stall_cnt, the compare against TIMEOUT_CYCLES, and the timeout_err register. Its inputs are grant_active and s_ready; its output is expire.

## Test plan
- **Single master:** m0 reads 0x100 and the slave answers after 2 cycles with 0x1234_5678.
  - s_valid rises 1 cycle after m0_valid.
  - m0_ready=1 with m0_rdata=0x1234_5678.
  - m1_ready stays 0.
- **Fairness:** both masters stay valid continuously and the slave acks each request after 1 cycle.
  - Grants alternate 0,1,0,1 starting with master 0.
  - Exactly one IDLE cycle separates grants.
- **Write forwarding:** m1 writes 0xA5 with wstrb=4'b0001 to 0x0200_0000.
  - s_addr, s_wdata and s_wstrb match m1's values exactly while granted.
  - m1_ready follows s_ready.
- **Timeout:** TIMEOUT_CYCLES=4 and s_ready is held at 0.
  - s_valid is high for 4 cycles.
  - In the 5th cycle m0_ready=1, m0_rdata=0xDEAD_BEEF and s_valid=0.
  - timeout_err pulses in the next cycle; state is IDLE.
- **Collision at expiry:** s_ready=1 arrives exactly in the expiry cycle.
  - The master gets the slave data, not ERR_RDATA.
  - timeout_err stays 0.
- **Reset and abort:** resetn=0 mid-grant → all outputs are 0 on the next cycle and the first tie after reset goes to master 0. Separately, m1 drops valid while granted → IDLE with m1_ready never asserted.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native memory bus: arbiter state encoding,
// the error read pattern, and the decoder address map used by the firmware.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  // Read data a master receives when the watchdog ends its transfer.
  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

  // Memory-mapped peripheral addresses decoded downstream of the arbiter.
  localparam logic [31:0] LED_ADDR       = 32'h0200_0000;
  localparam logic [31:0] UART_DIV_ADDR  = 32'h0200_0004;
  localparam logic [31:0] UART_DATA_ADDR = 32'h0200_0008;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Per-transaction stall watchdog. Counts granted cycles without a slave
// response and flags the cycle in which the tolerated stall is used up.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic grant_active,
  input  logic s_ready,
  output logic expire,
  output logic timeout_err
);

  // A zero timeout disables the watchdog; keep the counter one bit wide then.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] stall_cnt;

  // Expiry only when the slave is still silent; a late response wins.
  assign expire = (TIMEOUT_CYCLES != 0) && grant_active && !s_ready
                  && (stall_cnt == LIMIT);

  // Stall counter: zero outside a grant, saturates at the limit.
  always_ff @(posedge clk) begin
    if (!resetn || !grant_active) begin
      stall_cnt <= '0;
    end else if (!s_ready && (stall_cnt != LIMIT)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Error pulse registered so it appears the cycle after the forced completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one native memory slave port.
// Handshake: a master raises mX_valid with stable addr/wdata/wstrb/instr and
// holds them until mX_ready is high in a cycle; that cycle completes the
// transfer. The slave sees the same rule on s_valid/s_ready, and the ready
// path back to the granted master is purely combinational.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = BUS_ERR_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err,
  output arb_state_t  state_dbg
);

  arb_state_t state, state_next, cur;
  logic       last_grant;
  logic       grant_active;
  logic       expire;
  logic       wd_err;
  logic       sel1;
  logic       sel_valid;
  logic       ready_g;
  logic [31:0] rdata_g;

  // While reset is held the arbiter behaves as idle so every output is quiet.
  assign cur          = resetn ? state : ST_IDLE;
  assign sel1         = (cur == ST_GRANT1);
  assign grant_active = ((cur == ST_GRANT0) && m0_valid) ||
                        ((cur == ST_GRANT1) && m1_valid);
  assign timeout_err  = wd_err && resetn;
  assign state_dbg    = cur;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .resetn       (resetn),
    .grant_active (grant_active),
    .s_ready      (s_ready),
    .expire       (expire),
    .timeout_err  (wd_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember who owned the bus last so the other master wins the next tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if ((cur != ST_IDLE) && (state_next == ST_IDLE)) begin
      last_grant <= sel1;
    end
  end

  // Arbitration, request forwarding and completion routing.
  always_comb begin
    state_next = cur;
    s_valid    = 1'b0;
    s_instr    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m0_ready   = 1'b0;
    m0_rdata   = '0;
    m1_ready   = 1'b0;
    m1_rdata   = '0;
    sel_valid  = 1'b0;
    ready_g    = 1'b0;
    rdata_g    = '0;
    if (cur == ST_IDLE) begin
      if (m0_valid && (!m1_valid || last_grant)) begin
        state_next = ST_GRANT0;
      end else if (m1_valid) begin
        state_next = ST_GRANT1;
      end
    end else begin
      sel_valid = sel1 ? m1_valid : m0_valid;
      s_valid   = sel_valid && !expire;
      s_instr   = sel1 ? m1_instr : m0_instr;
      s_addr    = sel1 ? m1_addr  : m0_addr;
      s_wdata   = sel1 ? m1_wdata : m0_wdata;
      s_wstrb   = sel1 ? m1_wstrb : m0_wstrb;
      rdata_g   = expire ? ERR_RDATA : s_rdata;
      ready_g   = sel_valid && (s_ready || expire);
      if (sel1) begin
        m1_ready = ready_g;
        m1_rdata = rdata_g;
      end else begin
        m0_ready = ready_g;
        m0_rdata = rdata_g;
      end
      // Completion, forced error or a master abandoning its request all end the grant.
      if (!sel_valid || ready_g) begin
        state_next = ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int T_CYC = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        timeout_err;
  arb_state_t  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T_CYC), .ERR_RDATA(BUS_ERR_RDATA)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Transaction-level model: who owns the bus, how long it has waited,
  // who owned it last, and whether an error pulse is owed.
  int          mdl_owner = -1;
  int          mdl_last  = 1;
  int          mdl_age   = 0;
  bit          mdl_errp  = 1'b0;
  bit          e_sv, e_si, e_r0, e_r1, e_err, v, to, rdy;
  logic [31:0] e_sa, e_sd, e_d0, e_d1, rd;
  logic [3:0]  e_sw;
  arb_state_t  e_st;

  always @(negedge clk) begin
    e_sv = 0; e_si = 0; e_sa = '0; e_sd = '0; e_sw = '0;
    e_r0 = 0; e_r1 = 0; e_d0 = '0; e_d1 = '0; e_err = 0; e_st = ST_IDLE;
    if (!resetn) begin
      chk_all();
      mdl_owner = -1; mdl_last = 1; mdl_age = 0; mdl_errp = 0;
    end else begin
      e_err = mdl_errp;
      mdl_errp = 0;
      if (mdl_owner < 0) begin
        chk_all();
        if (m0_valid && (!m1_valid || mdl_last == 1)) begin
          mdl_owner = 0; mdl_age = 0;
        end else if (m1_valid) begin
          mdl_owner = 1; mdl_age = 0;
        end
      end else begin
        e_st = (mdl_owner == 0) ? ST_GRANT0 : ST_GRANT1;
        v    = (mdl_owner == 0) ? m0_valid : m1_valid;
        e_si = (mdl_owner == 0) ? m0_instr : m1_instr;
        e_sa = (mdl_owner == 0) ? m0_addr  : m1_addr;
        e_sd = (mdl_owner == 0) ? m0_wdata : m1_wdata;
        e_sw = (mdl_owner == 0) ? m0_wstrb : m1_wstrb;
        to   = (mdl_age == T_CYC) && v && !s_ready;
        e_sv = v && !to;
        rdy  = v && (s_ready || to);
        rd   = to ? BUS_ERR_RDATA : s_rdata;
        if (mdl_owner == 0) begin e_r0 = rdy; e_d0 = rd; end
        else begin e_r1 = rdy; e_d1 = rd; end
        chk_all();
        mdl_errp = to;
        if (!v || rdy) begin
          mdl_last = mdl_owner; mdl_owner = -1;
        end else begin
          mdl_age++;
        end
      end
    end
  end

  task automatic chk_all();
    chk("m_svalid", {31'd0, s_valid}, {31'd0, e_sv});
    chk("m_sinstr", {31'd0, s_instr}, {31'd0, e_si});
    chk("m_saddr",  s_addr, e_sa);
    chk("m_swdata", s_wdata, e_sd);
    chk("m_swstrb", {28'd0, s_wstrb}, {28'd0, e_sw});
    chk("m_ready0", {31'd0, m0_ready}, {31'd0, e_r0});
    chk("m_rdata0", m0_rdata, e_d0);
    chk("m_ready1", {31'd0, m1_ready}, {31'd0, e_r1});
    chk("m_rdata1", m1_rdata, e_d1);
    chk("m_err",    {31'd0, timeout_err}, {31'd0, e_err});
    chk("m_state",  {30'd0, state_dbg}, {30'd0, e_st});
  endtask

  int high, n_gr, idle_gap, age;
  bit prev_sv, m0_done, m1_done;
  logic [31:0] e;

  initial begin
    // Reset.
    resetn = 1'b0;
    repeat (3) cyc();
    smp();
    chk("rst_svalid", {31'd0, s_valid}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    cyc();
    resetn = 1'b1;

    // Single master read with a delayed slave answer.
    cyc();
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'b0000;
    smp();
    chk("single_idle_svalid", {31'd0, s_valid}, 32'd0);
    cyc();
    smp();
    chk("single_svalid", {31'd0, s_valid}, 32'd1);
    chk("single_saddr", s_addr, 32'h100);
    cyc();
    smp();
    chk("single_wait_ready", {31'd0, m0_ready}, 32'd0);
    cyc();
    s_ready = 1; s_rdata = 32'h1234_5678;
    smp();
    chk("single_ready", {31'd0, m0_ready}, 32'd1);
    chk("single_rdata", m0_rdata, 32'h1234_5678);
    chk("single_m1_ready", {31'd0, m1_ready}, 32'd0);
    cyc();
    m0_valid = 0; s_ready = 0;
    smp();
    chk("single_back_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Reset in the middle of a grant.
    cyc();
    m0_valid = 1; m0_addr = 32'h200;
    cyc();
    smp();
    chk("rstmid_svalid_before", {31'd0, s_valid}, 32'd1);
    cyc();
    resetn = 0;
    smp();
    chk("rstmid_svalid", {31'd0, s_valid}, 32'd0);
    chk("rstmid_saddr", s_addr, 32'd0);
    chk("rstmid_ready", {31'd0, m0_ready}, 32'd0);

    // Fairness: both masters always requesting, slave answers in the second cycle.
    cyc();
    resetn = 1;
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'h20;
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
    prev_sv = 0; n_gr = 0; idle_gap = 0; age = 0;
    for (int i = 0; i < 13; i++) begin
      smp();
      if (s_valid && !prev_sv) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("fair_grant", {31'd0, s_addr == 32'h20}, e);
          if (n_gr > 0) chk("fair_gap", idle_gap, 32'd1);
        end
        n_gr++;
        idle_gap = 0;
      end else if (!s_valid) begin
        idle_gap++;
      end
      prev_sv = s_valid;
      cyc();
      age = s_valid ? age + 1 : 0;
      s_ready = (age == 2);
      s_rdata = $urandom;
    end
    chk("fair_count", n_gr, 32'd4);
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    cyc(); cyc();

    // Write forwarding from master 1.
    m1_valid = 1; m1_addr = LED_ADDR; m1_wdata = 32'hA5; m1_wstrb = 4'b0001; m1_instr = 0;
    cyc();
    smp();
    chk("wr_svalid", {31'd0, s_valid}, 32'd1);
    chk("wr_saddr", s_addr, 32'h0200_0000);
    chk("wr_swdata", s_wdata, 32'hA5);
    chk("wr_swstrb", {28'd0, s_wstrb}, 32'd1);
    chk("wr_ready_wait", {31'd0, m1_ready}, 32'd0);
    cyc();
    s_ready = 1;
    smp();
    chk("wr_ready", {31'd0, m1_ready}, 32'd1);
    chk("wr_m0_ready", {31'd0, m0_ready}, 32'd0);
    cyc();
    m1_valid = 0; s_ready = 0;
    cyc();

    // Abort: master 1 withdraws while granted.
    m1_valid = 1; m1_addr = 32'h40; m1_wstrb = 0;
    cyc();
    smp();
    chk("abort_granted", {30'd0, state_dbg}, {30'd0, ST_GRANT1});
    cyc();
    m1_valid = 0;
    smp();
    chk("abort_ready", {31'd0, m1_ready}, 32'd0);
    chk("abort_svalid", {31'd0, s_valid}, 32'd0);
    cyc();
    smp();
    chk("abort_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Timeout with a silent slave.
    cyc();
    m0_valid = 1; m0_addr = 32'h300; m0_wstrb = 0;
    smp();
    high = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      smp();
      if (s_valid) high++;
      else break;
    end
    chk("to_high_cycles", high, T_CYC);
    chk("to_svalid", {31'd0, s_valid}, 32'd0);
    chk("to_ready", {31'd0, m0_ready}, 32'd1);
    chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("to_err_early", {31'd0, timeout_err}, 32'd0);
    cyc();
    m0_valid = 0;
    smp();
    chk("to_err_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    cyc();
    smp();
    chk("to_err_clear", {31'd0, timeout_err}, 32'd0);

    // Slave answer landing exactly in the expiry cycle.
    cyc();
    m0_valid = 1; m0_addr = 32'h400;
    repeat (T_CYC) begin cyc(); end
    cyc();
    s_ready = 1; s_rdata = 32'hCAFE_F00D;
    smp();
    chk("coll_ready", {31'd0, m0_ready}, 32'd1);
    chk("coll_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("coll_err_now", {31'd0, timeout_err}, 32'd0);
    cyc();
    m0_valid = 0; s_ready = 0;
    smp();
    chk("coll_err_after", {31'd0, timeout_err}, 32'd0);

    // Randomized traffic with occasional aborts and resets.
    m0_done = 0; m1_done = 0;
    for (int c = 0; c < 3000; c++) begin
      smp();
      m0_done = m0_ready;
      m1_done = m1_ready;
      cyc();
      resetn = ($urandom_range(0, 299) != 0);
      if (!m0_valid || m0_done) begin
        m0_valid = $urandom_range(0, 1);
        m0_instr = $urandom_range(0, 1);
        m0_addr  = $urandom;
        m0_wdata = $urandom;
        m0_wstrb = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      end else if ($urandom_range(0, 39) == 0) begin
        m0_valid = 0;
      end
      if (!m1_valid || m1_done) begin
        m1_valid = $urandom_range(0, 1);
        m1_instr = $urandom_range(0, 1);
        m1_addr  = $urandom;
        m1_wdata = $urandom;
        m1_wstrb = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      end else if ($urandom_range(0, 39) == 0) begin
        m1_valid = 0;
      end
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
    end
    smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
